// File: rtl/if_id_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_id_skid_pkg
// Brief  : Shared width, NOP encoding and skid-state encoding for the IF/ID stage.
// Rev    : 1.0  initial release
// ============================================================================
package if_id_skid_pkg;

   localparam int          IFID_XLEN      = 32;
   localparam logic [31:0] IFID_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } ifid_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_skid_if.sv
`default_nettype none
// ============================================================================
// Module : if_id_skid_if
// Brief  : Fetch-side and decode-side handshake bundle of the IF/ID stage.
// Rev    : 1.0  initial release
// ============================================================================
interface if_id_skid_if
   import if_id_skid_pkg::*;
#(
   parameter int XLEN = IFID_XLEN
);
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_pc;
   logic [XLEN-1:0] if_instr;
   logic            flush;
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_instr;
   logic [4:0]      iimm_shamt;
   logic [11:0]     iimm;
   logic [11:0]     simm;
   logic [11:0]     bimm;
   logic [19:0]     uimm;
   logic [19:0]     jimm;
   logic [31:0]     perf_stall_cnt;
   logic [31:0]     perf_flush_cnt;

   // Stage view: fetch and decode drive their handshake inputs.
   modport slave (
      input  if_valid, if_pc, if_instr, flush, id_ready,
      output if_ready, id_valid, id_pc, id_instr,
             iimm_shamt, iimm, simm, bimm, uimm, jimm,
             perf_stall_cnt, perf_flush_cnt
   );

   modport master (
      output if_valid, if_pc, if_instr, flush, id_ready,
      input  if_ready, id_valid, id_pc, id_instr,
             iimm_shamt, iimm, simm, bimm, uimm, jimm,
             perf_stall_cnt, perf_flush_cnt
   );

endinterface
`default_nettype wire

// File: rtl/if_id_skid_rv_imm_slice.sv
`default_nettype none
// ============================================================================
// Module : rv_imm_slice
// Brief  : Raw RV32 immediate field extraction, usable by any stage.
// Rev    : 1.0  initial release
// ============================================================================
module rv_imm_slice (
   input  logic [31:0] i_instr,
   output logic [4:0]  o_iimm_shamt,
   output logic [11:0] o_iimm,
   output logic [11:0] o_simm,
   output logic [11:0] o_bimm,
   output logic [19:0] o_uimm,
   output logic [19:0] o_jimm
);
   // Opcode bits carry no immediate content.
   logic w_unused_opcode;
   assign w_unused_opcode = ^i_instr[6:0];

   assign o_iimm_shamt = i_instr[24:20];
   assign o_iimm       = i_instr[31:20];
   assign o_simm       = {i_instr[31:25], i_instr[11:7]};
   assign o_bimm       = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8]};
   assign o_uimm       = i_instr[31:12];
   assign o_jimm       = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21]};

endmodule
`default_nettype wire

// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module : if_id_skid
// Brief  : Fetch-to-decode stage with a 2-entry skid buffer and immediate slicing.
//          Optional performance counters enabled by IFID_PERF_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module if_id_skid
   import if_id_skid_pkg::*;
#(
   parameter int              XLEN      = IFID_XLEN,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IFID_NOP_INSTR)
) (
   input  logic         clk,
   input  logic         rstn,
   if_id_skid_if.slave  bus
);

   ifid_state_e     r_state;
   ifid_state_e     w_state_nxt;
   logic            r_if_ready;
   logic [XLEN-1:0] r_head_pc;
   logic [XLEN-1:0] r_head_instr;
   logic [XLEN-1:0] r_skid_pc;
   logic [XLEN-1:0] r_skid_instr;
   logic            w_id_valid;
   logic            w_acc;
   logic            w_pop;
   logic            w_load_head_in;
   logic            w_load_head_skid;
   logic            w_load_skid;
   logic [XLEN-1:0] w_id_instr;

   assign w_id_valid = (r_state != ST_EMPTY);
   assign w_acc      = bus.if_valid && r_if_ready;
   assign w_pop      = w_id_valid && bus.id_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_EMPTY;
         r_if_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_if_ready <= (w_state_nxt != ST_TWO);
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_head_in   = 1'b0;
      w_load_head_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_state_nxt    = ST_ONE;
               w_load_head_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_acc && w_pop) begin
               w_load_head_in = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = ST_TWO;
               w_load_skid = 1'b1;
            end else if (w_pop) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_pop) begin
               w_state_nxt      = ST_ONE;
               w_load_head_skid = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // A redirect discards everything, including a same-cycle accept.
      if (bus.flush) begin
         w_state_nxt      = ST_EMPTY;
         w_load_head_in   = 1'b0;
         w_load_head_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_head_pc    <= '0;
         r_head_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         r_skid_instr <= NOP_INSTR;
      end else begin
         if (w_load_head_in) begin
            r_head_pc    <= bus.if_pc;
            r_head_instr <= bus.if_instr;
         end else if (w_load_head_skid) begin
            r_head_pc    <= r_skid_pc;
            r_head_instr <= r_skid_instr;
         end
         if (w_load_skid) begin
            r_skid_pc    <= bus.if_pc;
            r_skid_instr <= bus.if_instr;
         end
      end
   end

   assign w_id_instr   = w_id_valid ? r_head_instr : NOP_INSTR;
   assign bus.if_ready = r_if_ready;
   assign bus.id_valid = w_id_valid;
   assign bus.id_pc    = r_head_pc;
   assign bus.id_instr = w_id_instr;

   rv_imm_slice u_imm_slice (
      .i_instr      (w_id_instr[31:0]),
      .o_iimm_shamt (bus.iimm_shamt),
      .o_iimm       (bus.iimm),
      .o_simm       (bus.simm),
      .o_bimm       (bus.bimm),
      .o_uimm       (bus.uimm),
      .o_jimm       (bus.jimm)
   );

`ifdef IFID_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   // A flush only counts when it actually discards a held entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_id_valid && !bus.id_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
         if (bus.flush && w_id_valid) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cnt = r_stall_cnt;
   assign bus.perf_flush_cnt = r_flush_cnt;
`else
   assign bus.perf_stall_cnt = 32'd0;
   assign bus.perf_flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
